// File: rtl/button_conditioner.sv
`timescale 1ns/1ps
// button_conditioner: synchronises, debounces and classifies four raw panel buttons.
// Ports: clock (rising edge), reset (async, active low), button[0:3] raw inputs,
//        press/rpt/release_pulse[0:3] one-cycle event pulses, held[0:3] level flag.
// All outputs are registered; a clean level change reaches an output 2 + DEBOUNCE_CYCLES
// edges after it is first sampled. Channels are fully independent.
module button_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 1000,
  parameter int         HOLD_CYCLES     = 5000,
  parameter int         REPEAT_CYCLES   = 1000,
  parameter logic [0:3] IDLE_LEVEL      = 4'b0001
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [0:3] button,
  output logic [0:3] press,
  output logic [0:3] held,
  output logic [0:3] rpt,
  output logic [0:3] release_pulse
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);

  localparam logic [CW-1:0] DEB_N  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] HOLD_N = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_N  = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] ZERO   = '0;

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_DEB_PRESS   = 2'd1;
  localparam logic [1:0] S_PRESSED     = 2'd2;
  localparam logic [1:0] S_DEB_RELEASE = 2'd3;

  // Two-flop synchroniser. Both stages preset to the idle level so a button
  // held through reset looks like a fresh edge and is fully re-debounced.
  logic [0:3] sync1;
  logic [0:3] sync2;
  logic [0:3] raw_p;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // Normalise polarity: 1 means "pressed" on every channel.
  assign raw_p = sync2 ^ IDLE_LEVEL;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic [1:0]    state;
    logic [CW-1:0] dcnt;   // debounce run length
    logic [CW-1:0] hcnt;   // hold time, saturates at HOLD_CYCLES
    logic [CW-1:0] rcnt;   // spacing between repeats once the hold has matured
    logic          press_r;
    logic          held_r;
    logic          rpt_r;
    logic          rel_r;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state   <= S_IDLE;
        dcnt    <= ZERO;
        hcnt    <= ZERO;
        rcnt    <= ZERO;
        press_r <= 1'b0;
        held_r  <= 1'b0;
        rpt_r   <= 1'b0;
        rel_r   <= 1'b0;
      end else begin
        // Event outputs are single-cycle unless re-asserted below.
        press_r <= 1'b0;
        rpt_r   <= 1'b0;
        rel_r   <= 1'b0;
        case (state)
          S_IDLE: begin
            if (raw_p[i]) begin
              state <= S_DEB_PRESS;
              dcnt  <= ONE;
            end
          end

          S_DEB_PRESS: begin
            if (!raw_p[i]) begin
              state <= S_IDLE;
              dcnt  <= ZERO;
            end else if (dcnt >= DEB_N) begin
              // The transition is taken on the sample after the run reaches
              // DEBOUNCE_CYCLES, giving the exact 2 + DEBOUNCE_CYCLES latency.
              state   <= S_PRESSED;
              press_r <= 1'b1;
              held_r  <= 1'b1;
              dcnt    <= ZERO;
              hcnt    <= ZERO;
              rcnt    <= ZERO;
            end else begin
              dcnt <= dcnt + ONE;
            end
          end

          S_PRESSED: begin
            if (!raw_p[i]) begin
              // hcnt/rcnt are left untouched so a bounce resumes the hold.
              state <= S_DEB_RELEASE;
              dcnt  <= ONE;
            end else if (hcnt < HOLD_N) begin
              hcnt <= hcnt + ONE;
              if (hcnt == HOLD_N - ONE) begin
                rpt_r <= 1'b1;
                rcnt  <= ZERO;
              end
            end else if (rcnt >= REP_N - ONE) begin
              // hcnt is saturated; rcnt times the repeat interval instead so
              // no counter ever wraps however long the button is held.
              rpt_r <= 1'b1;
              rcnt  <= ZERO;
            end else begin
              rcnt <= rcnt + ONE;
            end
          end

          S_DEB_RELEASE: begin
            if (raw_p[i]) begin
              state <= S_PRESSED;
              dcnt  <= ZERO;
            end else if (dcnt >= DEB_N) begin
              state  <= S_IDLE;
              rel_r  <= 1'b1;
              held_r <= 1'b0;
              dcnt   <= ZERO;
            end else begin
              dcnt <= dcnt + ONE;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end

    assign press[i]         = press_r;
    assign held[i]          = held_r;
    assign rpt[i]           = rpt_r;
    assign release_pulse[i] = rel_r;
  end

endmodule

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
module tb_button_conditioner;

  logic       clock  = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset  = 1'b1;
  logic [0:3] button = 4'b0000;  // button[3] starts pressed (it idles high)
  logic [0:3] press, held, rpt, release_pulse;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  localparam int K_PRESS = 0;
  localparam int K_RPT   = 1;
  localparam int K_REL   = 2;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } evt_t;

  evt_t exp_q[$];

  button_conditioner dut (
    .clock        (clock),
    .reset        (reset),
    .button       (button),
    .press        (press),
    .held         (held),
    .rpt          (rpt),
    .release_pulse(release_pulse)
  );

  always #1 if (clk_en) clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_evt(input int c, input int ch, input int k);
    evt_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  // Return at the falling edge following rising edge n.
  task automatic at_edge(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  // Monitor: every pulse seen must match the head of the expectation queue.
  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missed_evt: ch%0d kind%0d never seen, expected at cycle %0d (now %0d)",
               exp_q[0].ch, exp_q[0].kind, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    for (int ch = 0; ch < 4; ch++) begin
      for (int k = 0; k < 3; k++) begin
        logic hit;
        evt_t e;
        hit = (k == K_PRESS) ? press[ch] : (k == K_RPT) ? rpt[ch] : release_pulse[ch];
        if (hit) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_evt: got ch%0d kind%0d at cycle %0d, expected none",
                     ch, k, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.ch != ch || e.kind != k) begin
              n_fail++;
              $display("FAIL evt_order: got ch%0d kind%0d at cycle %0d, expected ch%0d kind%0d at cycle %0d",
                       ch, k, cyc, e.ch, e.kind, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected done", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int t1;

    // 1. Reset with no clock running, button[3] pressed throughout.
    #1 reset = 1'b0;
    #1;
    check("rst_press", int'(press), 0);
    check("rst_held", int'(held), 0);
    check("rst_rpt", int'(rpt), 0);
    check("rst_release", int'(release_pulse), 0);
    clk_en = 1'b1;
    at_edge(5);
    check("rst_held_clocked", int'(held), 0);
    reset = 1'b1;
    t0 = cyc + 1;
    expect_evt(t0 + 1002, 3, K_PRESS);
    at_edge(t0 + 1001);
    check("t1_held3_before", int'(held[3]), 0);
    at_edge(t0 + 1002);
    check("t1_held3_at_press", int'(held[3]), 1);
    at_edge(t0 + 1200);
    button[3] = 1'b1;
    t1 = cyc + 1;
    expect_evt(t1 + 1002, 3, K_REL);
    at_edge(t1 + 1001);
    check("t1_held3_before_rel", int'(held[3]), 1);
    at_edge(t1 + 1002);
    check("t1_held3_after_rel", int'(held[3]), 0);

    // 2. Short press on channel 0: 2500 cycles, no repeat.
    at_edge(cyc + 10);
    button[0] = 1'b1;
    t0 = cyc + 1;
    expect_evt(t0 + 1002, 0, K_PRESS);
    at_edge(t0 + 1001);
    check("t2_held0_before", int'(held[0]), 0);
    at_edge(t0 + 1002);
    check("t2_held0_at_press", int'(held[0]), 1);
    at_edge(t0 + 2499);
    button[0] = 1'b0;
    expect_evt(t0 + 3502, 0, K_REL);
    at_edge(t0 + 3501);
    check("t2_held0_before_rel", int'(held[0]), 1);
    at_edge(t0 + 3502);
    check("t2_held0_after_rel", int'(held[0]), 0);

    // 3. Long hold on channel 3 (active low): 22 repeats.
    at_edge(cyc + 10);
    button[3] = 1'b0;
    t0 = cyc + 1;
    expect_evt(t0 + 1002, 3, K_PRESS);
    for (int j = 0; j < 22; j++) expect_evt(t0 + 6002 + 1000 * j, 3, K_RPT);
    at_edge(t0 + 20000);
    check("t3_held3_mid", int'(held[3]), 1);
    at_edge(t0 + 27499);
    button[3] = 1'b1;
    expect_evt(t0 + 28502, 3, K_REL);
    at_edge(t0 + 28501);
    check("t3_held3_before_rel", int'(held[3]), 1);
    at_edge(t0 + 28502);
    check("t3_held3_after_rel", int'(held[3]), 0);

    // 4a. 500-cycle glitch on channel 1: nothing at all.
    at_edge(cyc + 10);
    button[1] = 1'b1;
    t0 = cyc + 1;
    at_edge(t0 + 499);
    button[1] = 1'b0;
    at_edge(t0 + 1002);
    check("t4_glitch_held1", int'(held[1]), 0);
    at_edge(t0 + 1300);
    check("t4_glitch_held1_late", int'(held[1]), 0);

    // 4b. Real press with a 300-cycle drop: no release until the final one.
    button[1] = 1'b1;
    t0 = cyc + 1;
    expect_evt(t0 + 1002, 1, K_PRESS);
    at_edge(t0 + 1999);
    button[1] = 1'b0;
    at_edge(t0 + 2299);
    button[1] = 1'b1;
    at_edge(t0 + 2500);
    check("t4_bounce_held1", int'(held[1]), 1);
    at_edge(t0 + 3002);
    check("t4_bounce_held1_late", int'(held[1]), 1);
    at_edge(t0 + 3299);
    button[1] = 1'b0;
    expect_evt(t0 + 4302, 1, K_REL);
    at_edge(t0 + 4301);
    check("t4_held1_before_rel", int'(held[1]), 1);
    at_edge(t0 + 4302);
    check("t4_held1_after_rel", int'(held[1]), 0);

    // 5. Channels 0 and 2 pressed on the same edge, then async reset mid-hold.
    at_edge(cyc + 10);
    button[0] = 1'b1;
    button[2] = 1'b1;
    t0 = cyc + 1;
    expect_evt(t0 + 1002, 0, K_PRESS);
    expect_evt(t0 + 1002, 2, K_PRESS);
    expect_evt(t0 + 6002, 0, K_RPT);
    expect_evt(t0 + 6002, 2, K_RPT);
    at_edge(t0 + 1002);
    check("t5_held_both", int'(held), 4'b1010);
    at_edge(t0 + 6002);
    check("t5_rpt_both", int'(rpt), 4'b1010);
    #0.5 reset = 1'b0;
    #0.1;
    check("t5_reset_rpt", int'(rpt), 0);
    check("t5_reset_held", int'(held), 0);
    check("t5_queue_drained", exp_q.size(), 0);
    button = 4'b0001;
    at_edge(cyc + 5);
    reset = 1'b1;
    at_edge(cyc + 1500);
    check("t5_after_reset_held", int'(held), 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
